// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the MIPS ID/EX control slice: opcodes, ALUOp codes,
// exception causes, FSM states and the datapath control bundle.
package mips_ctrl_pkg;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpOri   = 6'b001101;

  localparam logic [2:0] AluOpMem   = 3'b000;
  localparam logic [2:0] AluOpBeq   = 3'b001;
  localparam logic [2:0] AluOpRtype = 3'b010;
  localparam logic [2:0] AluOpLui   = 3'b011;
  localparam logic [2:0] AluOpOri   = 3'b100;
  localparam logic [2:0] AluOpExc   = 3'b111;

  localparam logic [1:0] CauseNone  = 2'b00;
  localparam logic [1:0] CauseUndef = 2'b01;
  localparam logic [1:0] CauseRsvd  = 2'b10;

  typedef enum logic {
    StRun,
    StExcWait
  } state_e;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic alusrc;
    logic regdst;
    logic memtoreg;
    logic branch;
  } ctrl_t;

endpackage

// File: rtl/main_dec.sv
// Combinational main decoder: opcode to ALUOp code, datapath controls and a
// reserved-opcode flag.
module main_dec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output logic [2:0] alu_op,
  output logic       regwrite,
  output logic       memread,
  output logic       memwrite,
  output logic       alusrc,
  output logic       regdst,
  output logic       memtoreg,
  output logic       branch,
  output logic       reserved
);

  always_comb begin
    alu_op   = AluOpMem;
    regwrite = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    alusrc   = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    branch   = 1'b0;
    reserved = 1'b0;
    unique case (opcode)
      OpRtype: begin
        alu_op   = AluOpRtype;
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      OpLw: begin
        alu_op   = AluOpMem;
        regwrite = 1'b1;
        memread  = 1'b1;
        alusrc   = 1'b1;
        memtoreg = 1'b1;
      end
      OpSw: begin
        alu_op   = AluOpMem;
        memwrite = 1'b1;
        alusrc   = 1'b1;
      end
      OpBeq: begin
        alu_op = AluOpBeq;
        branch = 1'b1;
      end
      OpLui: begin
        alu_op   = AluOpLui;
        regwrite = 1'b1;
        alusrc   = 1'b1;
      end
      OpOri: begin
        alu_op   = AluOpOri;
        regwrite = 1'b1;
        alusrc   = 1'b1;
      end
      default: begin
        // Unknown opcode: flag it and keep every write/mem control off.
        alu_op   = AluOpExc;
        reserved = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_ex_ctrl.sv
// ID/EX control pipeline register with a registered exception request and
// req/ack handshake towards the exception unit.
module id_ex_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic [PC_W-1:0] id_pc,
  input  logic            stall,
  input  logic            flush,
  input  logic            ex_undefine,
  input  logic            exc_ack,
  output logic [2:0]      EX_ALUOp,
  output logic [5:0]      ex_func,
  output logic            ex_valid,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_alusrc,
  output logic            ex_regdst,
  output logic            ex_memtoreg,
  output logic            ex_branch,
  output logic            exc_req,
  output logic [1:0]      exc_cause,
  output logic [PC_W-1:0] exc_pc,
  output logic            hold_req
);

  logic [2:0] dec_alu_op;
  ctrl_t      dec_ctrl;
  logic       dec_rsvd;

  logic unused_instr;
  assign unused_instr = ^id_instr[25:6];

  main_dec u_main_dec (
    .opcode   (id_instr[31:26]),
    .alu_op   (dec_alu_op),
    .regwrite (dec_ctrl.regwrite),
    .memread  (dec_ctrl.memread),
    .memwrite (dec_ctrl.memwrite),
    .alusrc   (dec_ctrl.alusrc),
    .regdst   (dec_ctrl.regdst),
    .memtoreg (dec_ctrl.memtoreg),
    .branch   (dec_ctrl.branch),
    .reserved (dec_rsvd)
  );

  state_e          state_q, state_d;
  logic            valid_q, valid_d;
  logic [2:0]      aluop_q, aluop_d;
  logic [5:0]      func_q, func_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            rsvd_q, rsvd_d;
  logic            exc_req_q, exc_req_d;
  logic [1:0]      cause_q, cause_d;
  logic [PC_W-1:0] epc_q, epc_d;
  logic            hold_q, hold_d;

  logic do_bubble, do_load;

  always_comb begin
    state_d   = state_q;
    exc_req_d = exc_req_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    hold_d    = hold_q;
    do_bubble = 1'b0;
    do_load   = 1'b0;

    unique case (state_q)
      StRun: begin
        if (valid_q && (ex_undefine || rsvd_q)) begin
          exc_req_d = 1'b1;
          hold_d    = 1'b1;
          epc_d     = pc_q;
          cause_d   = rsvd_q ? CauseRsvd : CauseUndef;
          state_d   = StExcWait;
          do_bubble = 1'b1;
        end else if (flush) begin
          do_bubble = 1'b1;
        end else if (!stall) begin
          do_load   = id_valid;
          do_bubble = !id_valid;
        end
      end
      StExcWait: begin
        // Bubble on the ack edge too; the next ID instruction enters a cycle later.
        do_bubble = 1'b1;
        if (exc_ack) begin
          exc_req_d = 1'b0;
          hold_d    = 1'b0;
          state_d   = StRun;
        end
      end
      default: state_d = StRun;
    endcase

    valid_d = valid_q;
    aluop_d = aluop_q;
    func_d  = func_q;
    ctrl_d  = ctrl_q;
    pc_d    = pc_q;
    rsvd_d  = rsvd_q;
    if (do_bubble) begin
      valid_d = 1'b0;
      aluop_d = AluOpMem;
      func_d  = '0;
      ctrl_d  = '0;
      pc_d    = '0;
      rsvd_d  = 1'b0;
    end else if (do_load) begin
      valid_d = 1'b1;
      aluop_d = dec_alu_op;
      func_d  = id_instr[5:0];
      ctrl_d  = dec_ctrl;
      pc_d    = id_pc;
      rsvd_d  = dec_rsvd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      valid_q   <= 1'b0;
      aluop_q   <= AluOpMem;
      func_q    <= '0;
      ctrl_q    <= '0;
      pc_q      <= '0;
      rsvd_q    <= 1'b0;
      exc_req_q <= 1'b0;
      cause_q   <= CauseNone;
      epc_q     <= '0;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      aluop_q   <= aluop_d;
      func_q    <= func_d;
      ctrl_q    <= ctrl_d;
      pc_q      <= pc_d;
      rsvd_q    <= rsvd_d;
      exc_req_q <= exc_req_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      hold_q    <= hold_d;
    end
  end

  assign EX_ALUOp    = aluop_q;
  assign ex_func     = func_q;
  assign ex_valid    = valid_q;
  assign ex_regwrite = ctrl_q.regwrite;
  assign ex_memread  = ctrl_q.memread;
  assign ex_memwrite = ctrl_q.memwrite;
  assign ex_alusrc   = ctrl_q.alusrc;
  assign ex_regdst   = ctrl_q.regdst;
  assign ex_memtoreg = ctrl_q.memtoreg;
  assign ex_branch   = ctrl_q.branch;
  assign exc_req     = exc_req_q;
  assign exc_cause   = cause_q;
  assign exc_pc      = epc_q;
  assign hold_req    = hold_q;

endmodule

// File: tb/tb_id_ex_ctrl.sv
// Scoreboard bench for id_ex_ctrl: each stimulus cycle queues the expected
// outputs after its clock edge; a monitor pops and compares every cycle.
module tb_id_ex_ctrl;

  logic        clk = 1'b0;
  logic        rst, id_valid, stall, flush, ex_undefine, exc_ack;
  logic [31:0] id_instr, id_pc;
  logic [2:0]  EX_ALUOp;
  logic [5:0]  ex_func;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_alusrc;
  logic        ex_regdst, ex_memtoreg, ex_branch, exc_req, hold_req;
  logic [1:0]  exc_cause;
  logic [31:0] exc_pc;

  always #5 clk = ~clk;

  id_ex_ctrl #(.PC_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .stall       (stall),
    .flush       (flush),
    .ex_undefine (ex_undefine),
    .exc_ack     (exc_ack),
    .EX_ALUOp    (EX_ALUOp),
    .ex_func     (ex_func),
    .ex_valid    (ex_valid),
    .ex_regwrite (ex_regwrite),
    .ex_memread  (ex_memread),
    .ex_memwrite (ex_memwrite),
    .ex_alusrc   (ex_alusrc),
    .ex_regdst   (ex_regdst),
    .ex_memtoreg (ex_memtoreg),
    .ex_branch   (ex_branch),
    .exc_req     (exc_req),
    .exc_cause   (exc_cause),
    .exc_pc      (exc_pc),
    .hold_req    (hold_req)
  );

  // ctrl bits: {regwrite, memread, memwrite, alusrc, regdst, memtoreg, branch}
  typedef struct packed {
    logic        valid;
    logic [2:0]  aluop;
    logic [5:0]  func;
    logic [6:0]  ctrl;
    logic        req;
    logic [1:0]  cause;
    logic [31:0] epc;
    logic        hold;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  obs_t  act;

  always_comb act = {ex_valid, EX_ALUOp, ex_func, ex_regwrite, ex_memread, ex_memwrite,
                     ex_alusrc, ex_regdst, ex_memtoreg, ex_branch, exc_req, exc_cause,
                     exc_pc, hold_req};

  function automatic obs_t mk(logic v, logic [2:0] op, logic [5:0] fn, logic [6:0] c,
                              logic rq, logic [1:0] cs, logic [31:0] ep, logic hd);
    mk = {v, op, fn, c, rq, cs, ep, hd};
  endfunction

  function automatic obs_t bub(logic rq, logic [1:0] cs, logic [31:0] ep);
    bub = mk(1'b0, 3'b000, 6'b0, 7'b0, rq, cs, ep, rq);
  endfunction

  task automatic cyc(string nm, logic r, logic v, logic [31:0] ins, logic [31:0] pc,
                     logic st, logic fl, logic und, logic ack, obs_t e);
    rst = r; id_valid = v; id_instr = ins; id_pc = pc;
    stall = st; flush = fl; ex_undefine = und; exc_ack = ack;
    @(posedge clk);
    exp_q.push_back(e);
    name_q.push_back(nm);
    #1;
  endtask

  initial begin : monitor
    obs_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_cmp++;
        if (act !== e) begin
          n_bad++;
          $display("FAIL %s: actual v=%b op=%b fn=%b ctl=%b req=%b cause=%b epc=%h hold=%b | required v=%b op=%b fn=%b ctl=%b req=%b cause=%b epc=%h hold=%b",
                   nm, act.valid, act.aluop, act.func, act.ctrl, act.req, act.cause, act.epc,
                   act.hold, e.valid, e.aluop, e.func, e.ctrl, e.req, e.cause, e.epc, e.hold);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end

  localparam logic [31:0] IAdd  = 32'h0043_0820;
  localparam logic [31:0] ILw   = 32'h8C22_0004;
  localparam logic [31:0] ISw   = 32'hAC22_0008;
  localparam logic [31:0] IBeq  = 32'h1022_0003;
  localparam logic [31:0] ILui  = 32'h3C01_1234;
  localparam logic [31:0] IOri  = 32'h3421_5678;
  localparam logic [31:0] IRsv  = 32'hFC00_0000;
  localparam logic [31:0] IUndf = 32'h0000_0007;

  initial begin : stim
    obs_t e_ori, e_add;
    e_add = mk(1, 3'b010, 6'b100000, 7'b1000100, 0, 2'b00, 32'h0, 0);
    e_ori = mk(1, 3'b100, 6'b111000, 7'b1001000, 0, 2'b00, 32'h0, 0);

    // Reset and basic decode
    cyc("reset",   1, 0, 32'h0, 32'h0,  0, 0, 0, 0, bub(0, 2'b00, 32'h0));
    cyc("add",     0, 1, IAdd,  32'h00, 0, 0, 0, 0, e_add);
    cyc("lw",      0, 1, ILw,   32'h04, 0, 0, 0, 0,
        mk(1, 3'b000, 6'b000100, 7'b1101010, 0, 2'b00, 32'h0, 0));
    cyc("sw",      0, 1, ISw,   32'h08, 0, 0, 0, 0,
        mk(1, 3'b000, 6'b001000, 7'b0011000, 0, 2'b00, 32'h0, 0));
    cyc("beq",     0, 1, IBeq,  32'h0C, 0, 0, 0, 0,
        mk(1, 3'b001, 6'b000011, 7'b0000001, 0, 2'b00, 32'h0, 0));
    // exc_ack in RUN must be ignored
    cyc("lui_ack", 0, 1, ILui,  32'h10, 0, 0, 0, 1,
        mk(1, 3'b011, 6'b110100, 7'b1001000, 0, 2'b00, 32'h0, 0));
    cyc("ori",     0, 1, IOri,  32'h14, 0, 0, 0, 0, e_ori);

    // Stall freezes, flush beats stall, id_valid=0 loads a bubble
    cyc("stall1",  0, 1, IAdd,  32'h18, 1, 0, 0, 0, e_ori);
    cyc("stall2",  0, 1, IAdd,  32'h18, 1, 0, 0, 0, e_ori);
    cyc("flush_st",0, 1, IAdd,  32'h18, 1, 1, 0, 0, bub(0, 2'b00, 32'h0));
    cyc("idle",    0, 0, IAdd,  32'h18, 0, 0, 0, 0, bub(0, 2'b00, 32'h0));

    // Reserved opcode at 0x40, acked after 3 cycles
    cyc("rsv_ex",  0, 1, IRsv,  32'h40, 0, 0, 0, 0,
        mk(1, 3'b111, 6'b000000, 7'b0, 0, 2'b00, 32'h0, 0));
    cyc("rsv_req", 0, 1, IAdd,  32'h44, 0, 0, 0, 0, bub(1, 2'b10, 32'h40));
    cyc("rsv_w1",  0, 1, IAdd,  32'h44, 0, 0, 0, 0, bub(1, 2'b10, 32'h40));
    cyc("rsv_w2",  0, 1, IAdd,  32'h44, 0, 0, 0, 0, bub(1, 2'b10, 32'h40));
    cyc("rsv_ack", 0, 1, IAdd,  32'h44, 0, 0, 0, 1, bub(0, 2'b10, 32'h40));
    cyc("rsv_resume", 0, 1, IAdd, 32'h44, 0, 0, 0, 0,
        mk(1, 3'b010, 6'b100000, 7'b1000100, 0, 2'b10, 32'h40, 0));

    // Undefined func at 0x80; waiting ignores stall/flush/new ID
    cyc("und_ex",  0, 1, IUndf, 32'h80, 0, 0, 0, 0,
        mk(1, 3'b010, 6'b000111, 7'b1000100, 0, 2'b10, 32'h40, 0));
    cyc("und_req", 0, 1, IAdd,  32'h84, 0, 0, 1, 0, bub(1, 2'b01, 32'h80));
    cyc("und_stfl",0, 1, IAdd,  32'h84, 1, 1, 1, 0, bub(1, 2'b01, 32'h80));
    cyc("und_st",  0, 1, IOri,  32'h88, 1, 0, 0, 0, bub(1, 2'b01, 32'h80));
    cyc("und_ack", 0, 1, IOri,  32'h88, 0, 0, 0, 1, bub(0, 2'b01, 32'h80));
    cyc("und_resume", 0, 1, IOri, 32'h88, 0, 0, 0, 0,
        mk(1, 3'b100, 6'b111000, 7'b1001000, 0, 2'b01, 32'h80, 0));

    // Reserved opcode together with ex_undefine: reserved cause wins
    cyc("both_ex", 0, 1, IRsv,  32'hC0, 0, 0, 0, 0,
        mk(1, 3'b111, 6'b000000, 7'b0, 0, 2'b01, 32'h80, 0));
    cyc("both_req",0, 0, IAdd,  32'hC4, 0, 0, 1, 0, bub(1, 2'b10, 32'hC0));

    // Reset mid-wait clears everything
    cyc("rst_wait",0, 1, IAdd,  32'hC4, 0, 0, 0, 0, bub(1, 2'b10, 32'hC0));
    cyc("rst_mid", 1, 1, IAdd,  32'hC4, 0, 0, 0, 0, bub(0, 2'b00, 32'h0));

    // ex_undefine with nothing valid in EX raises nothing
    cyc("undf_nv1",0, 0, IAdd,  32'hC8, 0, 0, 1, 0, bub(0, 2'b00, 32'h0));
    cyc("undf_nv2",0, 0, IAdd,  32'hC8, 0, 0, 1, 0, bub(0, 2'b00, 32'h0));
    cyc("post_add",0, 1, IAdd,  32'hCC, 0, 0, 0, 0, e_add);

    id_valid = 0; ex_undefine = 0; exc_ack = 0; stall = 0; flush = 0;
    repeat (3) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: actual %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
